mem_arbiter: RTL and testbench

- Shares the single-port unified memory `mem` between the MIPS instruction-fetch port and the load/store data port.
- Arbitrates between the two requesters, range-checks addresses against the memory window, sequences each access through a small FSM and returns read data or an error.
- Sits between the core's fetch/LSU stages and the `mem` instance, and drives all of mem's control inputs.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, default window constants and the address-window check
// for mem_arbiter. No ports; imported by mem_arbiter.
// Latency: n/a. Backpressure: n/a.
package mem_arb_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // Which requester owns the access in flight
   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_t;

   localparam logic [31:0] BASE_ADDR  = 32'h8002_0000;
   localparam int unsigned MEM_BYTES  = 1048576;
   localparam int unsigned WORD_BYTES = 4;

   // 33-bit compare so a window ending at the top of the 32-bit space cannot wrap.
   function automatic logic addr_in_window(input logic [32:0] addr,
                                           input logic [32:0] base,
                                           input logic [32:0] bytes);
      return (addr >= base) && (addr < (base + bytes));
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified memory between instruction fetch and load/store.
// Latency: grant at T, response at T+2 (T+1 for an out-of-window/misaligned request).
// Backpressure: one access in flight; requests are held by the requester until gnt, which only fires in IDLE.
// Ports: clock/reset (sync, active-high); i_* fetch port (req/addr in, gnt/rvalid/rdata/err out);
//        d_* load/store port (req/we/addr/wdata/be in, gnt/rvalid/rdata/err out);
//        mem_* drive the memory instance, mem_data_out returns read data one cycle after issue.
module mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = mem_arb_pkg::BASE_ADDR,
   parameter int unsigned MEM_BYTES  = mem_arb_pkg::MEM_BYTES,
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    i_err,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_data_in,
   output logic                    mem_read_write,
   output logic                    mem_enable,
   output logic [DATA_WIDTH/8-1:0] mem_byte_we,
   input  logic [DATA_WIDTH-1:0]   mem_data_out
);
   import mem_arb_pkg::*;

   localparam int unsigned SW = $clog2(MAX_STREAK + 1);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(WORD_BYTES - 1);

   state_t                  state;
   src_t                    src_q;
   logic                    we_q;
   logic [SW-1:0]           streak;
   logic [DATA_WIDTH-1:0]   i_rdata_q;
   logic [DATA_WIDTH-1:0]   d_rdata_q;

   logic                    pick_i;
   logic                    pick_d;
   logic                    win_ok;
   logic                    win_we;
   logic [ADDR_WIDTH-1:0]   win_addr;

   // Winner selection. Only evaluated in IDLE and suppressed during reset so no
   // grant can leak out while the block is being cleared.
   always_comb begin
      pick_i = 1'b0;
      pick_d = 1'b0;
      if (!reset && state == ST_IDLE) begin
         if (i_req && (!d_req || streak == SW'(MAX_STREAK)))
            pick_i = 1'b1;
         else if (d_req)
            pick_d = 1'b1;
      end
   end

   assign i_gnt = pick_i;
   assign d_gnt = pick_d;

   // Address check on whichever port is winning. Fetches must be word aligned;
   // data addresses ignore the low bits.
   always_comb begin
      if (pick_i) begin
         win_addr = i_addr;
         win_we   = 1'b0;
         win_ok   = addr_in_window(33'(i_addr), 33'(BASE_ADDR), 33'(MEM_BYTES)) &&
                    ((i_addr & WORD_MASK) == '0);
      end else begin
         win_addr = d_addr;
         win_we   = d_we;
         win_ok   = addr_in_window(33'(d_addr), 33'(BASE_ADDR), 33'(MEM_BYTES));
      end
   end

   // mem_data_out is only valid during RESP, so read data is passed straight
   // through in that cycle and then held in the _q register until the next response.
   assign i_rdata = (state == ST_RESP && src_q == SRC_I) ? mem_data_out : i_rdata_q;
   assign d_rdata = (state == ST_RESP && src_q == SRC_D && !we_q) ? mem_data_out : d_rdata_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         src_q          <= SRC_I;
         we_q           <= 1'b0;
         streak         <= '0;
         i_rvalid       <= 1'b0;
         i_err          <= 1'b0;
         i_rdata_q      <= '0;
         d_rvalid       <= 1'b0;
         d_err          <= 1'b0;
         d_rdata_q      <= '0;
         mem_address    <= '0;
         mem_data_in    <= '0;
         mem_read_write <= 1'b0;
         mem_enable     <= 1'b0;
         mem_byte_we    <= '0;
      end else begin
         i_rvalid <= 1'b0;
         i_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;

         // Starvation guard: count data grants that overtook a waiting fetch.
         if (pick_i)
            streak <= '0;
         else if (pick_d && i_req) begin
            if (streak != SW'(MAX_STREAK))
               streak <= streak + SW'(1);
         end else if (state == ST_IDLE && !i_req)
            streak <= '0;

         case (state)
            ST_IDLE: begin
               if (pick_i || pick_d) begin
                  src_q <= pick_i ? SRC_I : SRC_D;
                  we_q  <= win_we;
                  if (win_ok) begin
                     state          <= ST_ISSUE;
                     mem_enable     <= 1'b1;
                     mem_address    <= win_addr & ~WORD_MASK;
                     mem_read_write <= ~win_we;
                     mem_byte_we    <= win_we ? d_be : '0;
                     if (pick_d)
                        mem_data_in <= d_wdata;
                  end else begin
                     // Error response goes out in the very next cycle; memory untouched.
                     state <= ST_ERR;
                     if (pick_i) begin
                        i_rvalid  <= 1'b1;
                        i_err     <= 1'b1;
                        i_rdata_q <= '0;
                     end else begin
                        d_rvalid  <= 1'b1;
                        d_err     <= 1'b1;
                        d_rdata_q <= '0;
                     end
                  end
               end
            end
            ST_ISSUE: begin
               state       <= ST_RESP;
               mem_enable  <= 1'b0;
               mem_byte_we <= '0;
               if (src_q == SRC_I)
                  i_rvalid <= 1'b1;
               else begin
                  d_rvalid <= 1'b1;
                  if (we_q)
                     d_rdata_q <= '0;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
               if (src_q == SRC_I)
                  i_rdata_q <= mem_data_out;
               else if (!we_q)
                  d_rdata_q <= mem_data_out;
            end
            ST_ERR: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle table plus hand sequences around mem_arbiter and a small memory model.
// Latency: n/a. Backpressure: n/a.
module tb_mem_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] A0  = 32'h8002_0000;
   localparam logic [31:0] A4  = 32'h8002_0004;
   localparam logic [31:0] BAD = 32'h8012_0000;
   localparam logic [31:0] MIS = 32'h8002_0002;
   localparam logic [31:0] Z   = 32'h0;
   localparam logic [31:0] DB  = 32'hDEAD_BEEF;
   localparam logic [31:0] FS  = 32'hFFFF_FFFF;
   localparam logic [31:0] FB  = 32'hFF00_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid, i_err;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic [31:0] mem_address, mem_data_in;
   logic        mem_read_write, mem_enable;
   logic [3:0]  mem_byte_we;
   logic [31:0] mem_data_out = '0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_read_write(mem_read_write), .mem_enable(mem_enable),
      .mem_byte_we(mem_byte_we), .mem_data_out(mem_data_out)
   );

   // Memory model: synchronous, byte-writable, read data one cycle after enable.
   logic [31:0] mem_model [0:255];
   logic [31:0] wtmp;
   always @(posedge clock) begin
      if (mem_enable) begin
         if (!mem_read_write) begin
            wtmp = mem_model[mem_address[9:2]];
            for (int b = 0; b < 4; b++)
               if (mem_byte_we[b]) wtmp[8*b +: 8] = mem_data_in[8*b +: 8];
            mem_model[mem_address[9:2]] <= wtmp;
         end else begin
            mem_data_out <= mem_model[mem_address[9:2]];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, ireq;
      logic [31:0] iaddr;
      logic        dreq, dwe;
      logic [31:0] daddr, dwdata;
      logic [3:0]  dbe;
      logic        igt, dgt, irv, ierr;
      logic [31:0] irdata;
      logic        drv, derr;
      logic [31:0] drdata;
      logic        men, mrw;
      logic [3:0]  mbe;
   } vec_t;

   vec_t vecs [20];

   initial begin
      string  seq;
      int     ngnt;
      for (int i = 0; i < 256; i++) mem_model[i] = '0;

      //          rst ireq iaddr dreq dwe daddr wdata be    | igt dgt irv ierr irdata drv derr drdata men mrw mbe
      vecs[0]  = '{H, H, A0,  H, H, A0,  DB, 4'hF,  L, L, L, L, Z,  L, L, Z,  L, L, 4'h0};
      vecs[1]  = '{H, H, A0,  H, H, A0,  DB, 4'hF,  L, L, L, L, Z,  L, L, Z,  L, L, 4'h0};
      vecs[2]  = '{H, H, A0,  H, H, A0,  DB, 4'hF,  L, L, L, L, Z,  L, L, Z,  L, L, 4'h0};
      vecs[3]  = '{L, H, A0,  H, H, A0,  DB, 4'hF,  L, H, L, L, Z,  L, L, Z,  L, L, 4'h0};
      vecs[4]  = '{L, H, A0,  L, H, A0,  DB, 4'hF,  L, L, L, L, Z,  L, L, Z,  H, L, 4'hF};
      vecs[5]  = '{L, H, A0,  L, H, A0,  DB, 4'hF,  L, L, L, L, Z,  H, L, Z,  L, L, 4'h0};
      vecs[6]  = '{L, H, A0,  L, H, A0,  DB, 4'hF,  H, L, L, L, Z,  L, L, Z,  L, L, 4'h0};
      vecs[7]  = '{L, L, A0,  L, L, A0,  Z,  4'h0,  L, L, L, L, Z,  L, L, Z,  H, H, 4'h0};
      vecs[8]  = '{L, L, A0,  L, L, A0,  Z,  4'h0,  L, L, H, L, DB, L, L, Z,  L, H, 4'h0};
      vecs[9]  = '{L, L, A0,  H, H, A4,  FS, 4'h8,  L, H, L, L, DB, L, L, Z,  L, H, 4'h0};
      vecs[10] = '{L, L, A0,  L, H, A4,  FS, 4'h8,  L, L, L, L, DB, L, L, Z,  H, L, 4'h8};
      vecs[11] = '{L, L, A0,  L, H, A4,  FS, 4'h8,  L, L, L, L, DB, H, L, Z,  L, L, 4'h0};
      vecs[12] = '{L, L, A0,  H, L, A4,  Z,  4'h0,  L, H, L, L, DB, L, L, Z,  L, L, 4'h0};
      vecs[13] = '{L, L, A0,  L, L, A4,  Z,  4'h0,  L, L, L, L, DB, L, L, Z,  H, H, 4'h0};
      vecs[14] = '{L, L, A0,  L, L, A4,  Z,  4'h0,  L, L, L, L, DB, H, L, FB, L, H, 4'h0};
      vecs[15] = '{L, L, A0,  H, L, BAD, Z,  4'h0,  L, H, L, L, DB, L, L, FB, L, H, 4'h0};
      vecs[16] = '{L, L, A0,  L, L, BAD, Z,  4'h0,  L, L, L, L, DB, H, H, Z,  L, H, 4'h0};
      vecs[17] = '{L, H, MIS, L, L, BAD, Z,  4'h0,  H, L, L, L, DB, L, L, Z,  L, H, 4'h0};
      vecs[18] = '{L, L, MIS, L, L, BAD, Z,  4'h0,  L, L, H, H, Z,  L, L, Z,  L, H, 4'h0};
      vecs[19] = '{L, L, MIS, L, L, BAD, Z,  4'h0,  L, L, L, L, Z,  L, L, Z,  L, H, 4'h0};

      // Reset, write then fetch, byte-lane write/readback, out-of-window and misaligned.
      for (int r = 0; r < 20; r++) begin
         @(posedge clock); #1;
         reset = vecs[r].rst; i_req = vecs[r].ireq; i_addr = vecs[r].iaddr;
         d_req = vecs[r].dreq; d_we = vecs[r].dwe; d_addr = vecs[r].daddr;
         d_wdata = vecs[r].dwdata; d_be = vecs[r].dbe;
         @(negedge clock);
         chk($sformatf("r%0d i_gnt", r),    32'(i_gnt),          32'(vecs[r].igt));
         chk($sformatf("r%0d d_gnt", r),    32'(d_gnt),          32'(vecs[r].dgt));
         chk($sformatf("r%0d i_rvalid", r), 32'(i_rvalid),       32'(vecs[r].irv));
         chk($sformatf("r%0d i_err", r),    32'(i_err),          32'(vecs[r].ierr));
         chk($sformatf("r%0d i_rdata", r),  i_rdata,             vecs[r].irdata);
         chk($sformatf("r%0d d_rvalid", r), 32'(d_rvalid),       32'(vecs[r].drv));
         chk($sformatf("r%0d d_err", r),    32'(d_err),          32'(vecs[r].derr));
         chk($sformatf("r%0d d_rdata", r),  d_rdata,             vecs[r].drdata);
         chk($sformatf("r%0d mem_enable", r), 32'(mem_enable),   32'(vecs[r].men));
         chk($sformatf("r%0d mem_rw", r),   32'(mem_read_write), 32'(vecs[r].mrw));
         chk($sformatf("r%0d mem_be", r),   32'(mem_byte_we),    32'(vecs[r].mbe));
      end

      // Contention: both ports hammer reads; expect 4 data grants then one fetch.
      seq = "";
      ngnt = 0;
      @(posedge clock); #1;
      i_req = 1'b1; i_addr = A0; d_req = 1'b1; d_we = 1'b0; d_addr = A0;
      for (int c = 0; c < 100 && ngnt < 10; c++) begin
         @(negedge clock);
         chk("contention exclusive gnt", 32'(i_gnt & d_gnt), 32'h0);
         if (d_gnt) begin seq = {seq, "D"}; ngnt++; end
         if (i_gnt) begin seq = {seq, "I"}; ngnt++; end
         @(posedge clock); #1;
      end
      checks++;
      if (seq != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL contention order: got %s expected DDDDIDDDDI", seq);
      end
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) @(posedge clock);
      #1;

      // Reset in the ISSUE cycle of a read abandons it silently.
      d_req = 1'b1; d_we = 1'b0; d_addr = A0;
      @(negedge clock);
      chk("rst-abort grant", 32'(d_gnt), 32'h1);
      @(posedge clock); #1;
      d_req = 1'b0; reset = 1'b1;
      @(negedge clock);
      chk("rst-abort issue", 32'(mem_enable), 32'h1);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         chk($sformatf("rst-abort no d_rvalid c%0d", c), 32'(d_rvalid), 32'h0);
         chk($sformatf("rst-abort no i_rvalid c%0d", c), 32'(i_rvalid), 32'h0);
         chk($sformatf("rst-abort idle mem c%0d", c), 32'(mem_enable), 32'h0);
      end
      @(posedge clock); #1;
      d_req = 1'b1;
      @(negedge clock);
      chk("post-reset grant", 32'(d_gnt), 32'h1);
      @(posedge clock); #1;
      d_req = 1'b0;
      @(negedge clock);
      chk("post-reset T+1 rvalid", 32'(d_rvalid), 32'h0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("post-reset T+2 rvalid", 32'(d_rvalid), 32'h1);
      chk("post-reset rdata", d_rdata, DB);
      @(posedge clock); #1;
      @(negedge clock);
      chk("post-reset rvalid pulse", 32'(d_rvalid), 32'h0);
      chk("post-reset rdata hold", d_rdata, DB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
